store_checker: RTL and testbench
================================

STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameter XLEN, default 32, data bus and address width in bits.
REQ-002 Parameter N_EXP, default 4, number of expected-store entries.
REQ-003 Parameter N_IGN, default 2, number of ignore-address entries.
REQ-004 Parameter TIMEOUT_CYC, default 1000, number of RUN cycles before a timeout failure.
REQ-005 Parameter ORDERED, default 1; 1 = expected stores must arrive in index order, 0 = any order.
REQ-006 Ports SHALL be, in order:
- clk  in  1  the single clock, rising-edge active.
- reset  in  1  synchronous reset, active-high.
- mem_write  in  1  store strobe from the core under observation.
- data_adr  in  XLEN  store address.
- write_data  in  XLEN  store data.
- cfg_we  in  1  config entry write.
- cfg_sel  in  1  0 = expect table, 1 = ignore table.
- cfg_idx  in  clog2(max(N_EXP,N_IGN))  entry index.
- cfg_addr  in  XLEN  entry address.
- cfg_data  in  XLEN  entry expected data; unused for the ignore table.
- start  in  1  arm the checker.
- clear  in  1  return to IDLE with the configuration kept.
- pass  out  1  result is pass.
- fail  out  1  result is fail.
- done  out  1  equals pass OR fail.
- fail_code  out  2  0 = none, 1 = unexpected address, 2 = data mismatch, 3 = timeout.
- fail_addr  out  XLEN  address of the offending store.
- fail_data  out  XLEN  data of the offending store.
- match_count  out  clog2(N_EXP+1)  number of expect entries matched so far.

Function
REQ-007 The FSM SHALL have the states IDLE, RUN, PASS and FAIL; all inputs are sampled on the rising edge of clk, and every output is registered.
REQ-008 cfg_we SHALL be accepted only in IDLE: it writes the addressed entry and sets its valid bit; an out-of-range cfg_idx is dropped.
REQ-009 start in IDLE SHALL move the FSM to RUN on the next edge, clearing the matched flags, match_count and the timer; start is ignored in every other state.
REQ-010 If start arrives with no valid expect entry, the FSM SHALL go directly to PASS.
REQ-011 In RUN, each mem_write cycle SHALL be classified with the following priority:
- expect hit: marks the entry matched and increments match_count.
- ignore hit: no action.
- otherwise: FAIL.
REQ-012 An expect hit SHALL require address equality and data equality with an eligible entry:
- ORDERED=1: the eligible entry is the lowest-index valid unmatched entry.
- ORDERED=0: the eligible entry is the lowest-index valid unmatched entry whose address and data both match.
REQ-013 A store whose address equals an eligible entry's address but whose data differs SHALL cause FAIL with code 2; any other non-hit, non-ignored store SHALL cause FAIL with code 1, including an out-of-order store when ORDERED=1.
REQ-014 The FSM SHALL go to PASS on the edge at which the last valid expect entry becomes matched.
REQ-015 The timer SHALL count RUN cycles; when it reaches TIMEOUT_CYC the FSM SHALL go to FAIL with code 3.
REQ-016 If the final match and the timeout occur in the same cycle, PASS SHALL win.
REQ-017 On entry to FAIL, fail_addr and fail_data SHALL capture the offending store; for a timeout they SHALL be 0.
REQ-018 PASS and FAIL SHALL be sticky: mem_write is ignored, and clear returns the FSM to IDLE with pass, fail, fail_code and match_count zeroed.
REQ-019 If start and clear are both asserted, clear SHALL win.
REQ-020 Latency: a store sampled at edge k SHALL be reflected in the outputs after edge k.

Reset
REQ-021 reset SHALL force IDLE, clear all valid bits, zero every output and the timer, and take priority over all other inputs, including in the middle of RUN.

Structure
REQ-022 Package store_checker_pkg SHALL hold the state enum, the fail_code enum and the fail_code constants.
REQ-023 Sub-module store_checker_table SHALL hold the entry storage and valid bits and produce the per-entry address/data compare vectors; the FSM, timer and priority logic stay in store_checker.

Verification
REQ-024 Expect[0]=(100,25), ign[0]=96, start; stores (96,7) then (100,25) -> pass=1 and match_count=1 one cycle after the second store.
REQ-025 Same configuration; store (100,24) -> fail=1, fail_code=2, fail_addr=100, fail_data=24.
REQ-026 Same configuration; store (104,7) -> fail_code=1; a following clear then start then (100,25) -> pass.
REQ-027 TIMEOUT_CYC=16, no stores -> fail_code=3 exactly 16 cycles after RUN entry; a final match in cycle 16 -> pass instead.
REQ-028 Expect[0]=(100,25), [1]=(104,9); store (104,9) first -> fail_code=1 with ORDERED=1, and pass after both stores with ORDERED=0.
REQ-029 reset asserted mid-RUN -> all outputs 0 and IDLE next cycle; start then gives an immediate pass, since the tables are empty.

Source files
------------

// File: rtl/store_checker_pkg.sv
// rtl/store_checker_pkg.sv - shared types and constants for the store checker
package store_checker_pkg;

  localparam logic [1:0] FAIL_CODE_NONE     = 2'd0;
  localparam logic [1:0] FAIL_CODE_UNEXP    = 2'd1;
  localparam logic [1:0] FAIL_CODE_DATA     = 2'd2;
  localparam logic [1:0] FAIL_CODE_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = FAIL_CODE_NONE,
    FC_UNEXP   = FAIL_CODE_UNEXP,
    FC_DATA    = FAIL_CODE_DATA,
    FC_TIMEOUT = FAIL_CODE_TIMEOUT
  } fail_code_e;

  // Shared index port width; never below one bit so single-entry tables still elaborate.
  function automatic int idx_width(int n_exp, int n_ign);
    int n;
    n = (n_exp > n_ign) ? n_exp : n_ign;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/store_checker_table.sv
// rtl/store_checker_table.sv - expect/ignore entry storage with per-entry compare vectors
module store_checker_table
  import store_checker_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int N_EXP = 4,
  parameter int N_IGN = 2,
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_we,
  input  logic             i_cfg_sel,
  input  logic [IDX_W-1:0] i_cfg_idx,
  input  logic [XLEN-1:0]  i_cfg_addr,
  input  logic [XLEN-1:0]  i_cfg_data,
  input  logic [XLEN-1:0]  i_st_addr,
  input  logic [XLEN-1:0]  i_st_data,
  output logic [N_EXP-1:0] o_exp_valid,
  output logic [N_EXP-1:0] o_exp_addr_eq,
  output logic [N_EXP-1:0] o_exp_data_eq,
  output logic [N_IGN-1:0] o_ign_hit
);

  logic [XLEN-1:0]  r_exp_addr [N_EXP];
  logic [XLEN-1:0]  r_exp_data [N_EXP];
  logic [N_EXP-1:0] r_exp_valid;
  logic [XLEN-1:0]  r_ign_addr [N_IGN];
  logic [N_IGN-1:0] r_ign_valid;

  // Out-of-range indices match no loop iteration and are dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_exp_valid <= '0;
      r_ign_valid <= '0;
    end else if (i_cfg_we) begin
      for (int i = 0; i < N_EXP; i++) begin
        if (!i_cfg_sel && (i_cfg_idx == IDX_W'(i))) begin
          r_exp_addr[i]  <= i_cfg_addr;
          r_exp_data[i]  <= i_cfg_data;
          r_exp_valid[i] <= 1'b1;
        end
      end
      for (int i = 0; i < N_IGN; i++) begin
        if (i_cfg_sel && (i_cfg_idx == IDX_W'(i))) begin
          r_ign_addr[i]  <= i_cfg_addr;
          r_ign_valid[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_exp_addr_eq = '0;
    o_exp_data_eq = '0;
    o_ign_hit     = '0;
    for (int i = 0; i < N_EXP; i++) begin
      o_exp_addr_eq[i] = (r_exp_addr[i] == i_st_addr);
      o_exp_data_eq[i] = (r_exp_data[i] == i_st_data);
    end
    for (int i = 0; i < N_IGN; i++) begin
      o_ign_hit[i] = r_ign_valid[i] && (r_ign_addr[i] == i_st_addr);
    end
  end

  assign o_exp_valid = r_exp_valid;

endmodule

// File: rtl/store_checker.sv
// rtl/store_checker.sv - observes core stores against an expect/ignore table and reports pass/fail
module store_checker
  import store_checker_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int N_EXP       = 4,
  parameter int N_IGN       = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int ORDERED     = 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    mem_write,
  input  logic [XLEN-1:0]                         data_adr,
  input  logic [XLEN-1:0]                         write_data,
  input  logic                                    cfg_we,
  input  logic                                    cfg_sel,
  input  logic [idx_width(N_EXP, N_IGN)-1:0]      cfg_idx,
  input  logic [XLEN-1:0]                         cfg_addr,
  input  logic [XLEN-1:0]                         cfg_data,
  input  logic                                    start,
  input  logic                                    clear,
  output logic                                    pass,
  output logic                                    fail,
  output logic                                    done,
  output logic [1:0]                              fail_code,
  output logic [XLEN-1:0]                         fail_addr,
  output logic [XLEN-1:0]                         fail_data,
  output logic [$clog2(N_EXP+1)-1:0]              match_count
);

  localparam int IDX_W = idx_width(N_EXP, N_IGN);
  localparam int MC_W  = $clog2(N_EXP + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  state_e           r_state, w_state_nx;
  logic [N_EXP-1:0] r_matched, w_matched_nx;
  logic [MC_W-1:0]  r_mc, w_mc_nx;
  logic [TW-1:0]    r_timer, w_timer_nx;
  logic             r_pass, w_pass_nx;
  logic             r_fail, w_fail_nx;
  logic             r_done, w_done_nx;
  fail_code_e       r_code, w_code_nx;
  logic [XLEN-1:0]  r_faddr, w_faddr_nx;
  logic [XLEN-1:0]  r_fdata, w_fdata_nx;

  logic             w_cfg_we;
  logic [N_EXP-1:0] w_exp_valid, w_addr_eq, w_data_eq;
  logic [N_IGN-1:0] w_ign_hit_vec;
  logic [N_EXP-1:0] w_pending, w_elig_oh, w_cand, w_cand_oh, w_hit_oh;
  logic             w_hit, w_ign, w_addr_only, w_last, w_timeout;

  assign w_cfg_we = cfg_we && (r_state == ST_IDLE);

  store_checker_table #(
    .XLEN  (XLEN),
    .N_EXP (N_EXP),
    .N_IGN (N_IGN),
    .IDX_W (IDX_W)
  ) u_table (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_cfg_we      (w_cfg_we),
    .i_cfg_sel     (cfg_sel),
    .i_cfg_idx     (cfg_idx),
    .i_cfg_addr    (cfg_addr),
    .i_cfg_data    (cfg_data),
    .i_st_addr     (data_adr),
    .i_st_data     (write_data),
    .o_exp_valid   (w_exp_valid),
    .o_exp_addr_eq (w_addr_eq),
    .o_exp_data_eq (w_data_eq),
    .o_ign_hit     (w_ign_hit_vec)
  );

  // x & -x isolates the lowest set bit, i.e. the lowest-index candidate.
  assign w_pending   = w_exp_valid & ~r_matched;
  assign w_elig_oh   = w_pending & (~w_pending + N_EXP'(1));
  assign w_cand      = w_pending & w_addr_eq & w_data_eq;
  assign w_cand_oh   = w_cand & (~w_cand + N_EXP'(1));
  assign w_hit_oh    = (ORDERED != 0) ? (w_elig_oh & w_addr_eq & w_data_eq) : w_cand_oh;
  assign w_addr_only = (ORDERED != 0) ? |(w_elig_oh & w_addr_eq) : |(w_pending & w_addr_eq);
  assign w_hit       = |w_hit_oh;
  assign w_ign       = |w_ign_hit_vec;
  assign w_last      = ((w_pending & ~w_hit_oh) == '0);
  assign w_timeout   = (r_timer == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_state_nx   = r_state;
    w_matched_nx = r_matched;
    w_mc_nx      = r_mc;
    w_timer_nx   = r_timer;
    w_pass_nx    = r_pass;
    w_fail_nx    = r_fail;
    w_code_nx    = r_code;
    w_faddr_nx   = r_faddr;
    w_fdata_nx   = r_fdata;

    if (clear) begin
      w_state_nx = ST_IDLE;
      w_mc_nx    = '0;
      w_timer_nx = '0;
      w_pass_nx  = 1'b0;
      w_fail_nx  = 1'b0;
      w_code_nx  = FC_NONE;
      w_faddr_nx = '0;
      w_fdata_nx = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_matched_nx = '0;
            w_mc_nx      = '0;
            w_timer_nx   = '0;
            if (w_exp_valid == '0) begin
              w_state_nx = ST_PASS;
              w_pass_nx  = 1'b1;
            end else begin
              w_state_nx = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          w_timer_nx = r_timer + TW'(1);
          if (mem_write && w_hit) begin
            w_matched_nx = r_matched | w_hit_oh;
            w_mc_nx      = r_mc + MC_W'(1);
            if (w_last) begin
              w_state_nx = ST_PASS;
              w_pass_nx  = 1'b1;
            end
          end else if (mem_write && !w_ign) begin
            w_state_nx = ST_FAIL;
            w_fail_nx  = 1'b1;
            w_code_nx  = w_addr_only ? FC_DATA : FC_UNEXP;
            w_faddr_nx = data_adr;
            w_fdata_nx = write_data;
          end
          // A store-driven PASS or FAIL this cycle outranks the timeout.
          if (w_timeout && (w_state_nx == ST_RUN)) begin
            w_state_nx = ST_FAIL;
            w_fail_nx  = 1'b1;
            w_code_nx  = FC_TIMEOUT;
            w_faddr_nx = '0;
            w_fdata_nx = '0;
          end
        end
        default: begin
        end
      endcase
    end
    w_done_nx = w_pass_nx | w_fail_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_matched <= '0;
      r_mc      <= '0;
      r_timer   <= '0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_done    <= 1'b0;
      r_code    <= FC_NONE;
      r_faddr   <= '0;
      r_fdata   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_matched <= w_matched_nx;
      r_mc      <= w_mc_nx;
      r_timer   <= w_timer_nx;
      r_pass    <= w_pass_nx;
      r_fail    <= w_fail_nx;
      r_done    <= w_done_nx;
      r_code    <= w_code_nx;
      r_faddr   <= w_faddr_nx;
      r_fdata   <= w_fdata_nx;
    end
  end

  assign pass        = r_pass;
  assign fail        = r_fail;
  assign done        = r_done;
  assign fail_code   = r_code;
  assign fail_addr   = r_faddr;
  assign fail_data   = r_fdata;
  assign match_count = r_mc;

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - directed vector bench driving an ordered and an unordered checker in parallel
module tb_store_checker;

  typedef struct {
    logic        rst, we, sel;
    logic [1:0]  idx;
    logic [31:0] caddr, cdata;
    logic        start, clr, mw;
    logic [31:0] adr, wd;
  } in_t;

  typedef struct {
    logic        p, f;
    logic [1:0]  c;
    logic [31:0] fa, fd;
    logic [2:0]  mc;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t a;
    exp_t b;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, mem_write, cfg_we, cfg_sel, start, clear;
  logic [31:0] data_adr, write_data, cfg_addr, cfg_data;
  logic [1:0]  cfg_idx;

  logic        a_pass, a_fail, a_done, b_pass, b_fail, b_done;
  logic [1:0]  a_code, b_code;
  logic [31:0] a_faddr, a_fdata, b_faddr, b_fdata;
  logic [2:0]  a_mc, b_mc;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  store_checker #(.XLEN(32), .N_EXP(4), .N_IGN(2), .TIMEOUT_CYC(16), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .clear(clear), .pass(a_pass), .fail(a_fail), .done(a_done), .fail_code(a_code),
    .fail_addr(a_faddr), .fail_data(a_fdata), .match_count(a_mc)
  );

  store_checker #(.XLEN(32), .N_EXP(4), .N_IGN(2), .TIMEOUT_CYC(16), .ORDERED(0)) u_any (
    .clk(clk), .reset(reset), .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .clear(clear), .pass(b_pass), .fail(b_fail), .done(b_done), .fail_code(b_code),
    .fail_addr(b_faddr), .fail_data(b_fdata), .match_count(b_mc)
  );

  function automatic in_t nop();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic in_t rst_i();
    in_t v = nop();
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic in_t cfg(logic sel, logic [1:0] idx, logic [31:0] a, logic [31:0] d);
    in_t v = nop();
    v.we = 1'b1; v.sel = sel; v.idx = idx; v.caddr = a; v.cdata = d;
    return v;
  endfunction

  function automatic in_t st();
    in_t v = nop();
    v.start = 1'b1;
    return v;
  endfunction

  function automatic in_t clr(logic also_start);
    in_t v = nop();
    v.clr = 1'b1; v.start = also_start;
    return v;
  endfunction

  function automatic in_t wr(logic [31:0] a, logic [31:0] d);
    in_t v = nop();
    v.mw = 1'b1; v.adr = a; v.wd = d;
    return v;
  endfunction

  function automatic exp_t e(logic p, logic f, logic [1:0] c, logic [31:0] fa, logic [31:0] fd, logic [2:0] mc);
    exp_t x;
    x.p = p; x.f = f; x.c = c; x.fa = fa; x.fd = fd; x.mc = mc;
    return x;
  endfunction

  function automatic exp_t z();
    return e(0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic apply(in_t v);
    reset      = v.rst;
    cfg_we     = v.we;
    cfg_sel    = v.sel;
    cfg_idx    = v.idx;
    cfg_addr   = v.caddr;
    cfg_data   = v.cdata;
    start      = v.start;
    clear      = v.clr;
    mem_write  = v.mw;
    data_adr   = v.adr;
    write_data = v.wd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(string tag, exp_t ea, exp_t eb);
    chk({tag, " ord.pass"}, 32'(a_pass), 32'(ea.p));
    chk({tag, " ord.fail"}, 32'(a_fail), 32'(ea.f));
    chk({tag, " ord.done"}, 32'(a_done), 32'(ea.p | ea.f));
    chk({tag, " ord.code"}, 32'(a_code), 32'(ea.c));
    chk({tag, " ord.faddr"}, a_faddr, ea.fa);
    chk({tag, " ord.fdata"}, a_fdata, ea.fd);
    chk({tag, " ord.mc"}, 32'(a_mc), 32'(ea.mc));
    chk({tag, " any.pass"}, 32'(b_pass), 32'(eb.p));
    chk({tag, " any.fail"}, 32'(b_fail), 32'(eb.f));
    chk({tag, " any.done"}, 32'(b_done), 32'(eb.p | eb.f));
    chk({tag, " any.code"}, 32'(b_code), 32'(eb.c));
    chk({tag, " any.faddr"}, b_faddr, eb.fa);
    chk({tag, " any.fdata"}, b_fdata, eb.fd);
    chk({tag, " any.mc"}, 32'(b_mc), 32'(eb.mc));
  endtask

  initial begin
    apply(nop());

    vecs.push_back('{rst_i(),               z(), z()});
    vecs.push_back('{cfg(0, 0, 100, 25),    z(), z()});
    vecs.push_back('{cfg(1, 0, 96, 0),      z(), z()});
    vecs.push_back('{st(),                  z(), z()});
    vecs.push_back('{wr(96, 7),             z(), z()});
    vecs.push_back('{wr(100, 25),           e(1, 0, 0, 0, 0, 1),     e(1, 0, 0, 0, 0, 1)});
    vecs.push_back('{wr(104, 7),            e(1, 0, 0, 0, 0, 1),     e(1, 0, 0, 0, 0, 1)});
    vecs.push_back('{clr(0),                z(), z()});
    vecs.push_back('{st(),                  z(), z()});
    vecs.push_back('{wr(100, 24),           e(0, 1, 2, 100, 24, 0),  e(0, 1, 2, 100, 24, 0)});
    vecs.push_back('{clr(1),                z(), z()});
    vecs.push_back('{wr(100, 25),           z(), z()});
    vecs.push_back('{st(),                  z(), z()});
    vecs.push_back('{wr(104, 7),            e(0, 1, 1, 104, 7, 0),   e(0, 1, 1, 104, 7, 0)});
    vecs.push_back('{clr(0),                z(), z()});
    vecs.push_back('{st(),                  z(), z()});
    vecs.push_back('{wr(100, 25),           e(1, 0, 0, 0, 0, 1),     e(1, 0, 0, 0, 0, 1)});
    vecs.push_back('{clr(0),                z(), z()});
    vecs.push_back('{cfg(0, 1, 104, 9),     z(), z()});
    vecs.push_back('{cfg(1, 2, 200, 0),     z(), z()});
    vecs.push_back('{st(),                  z(), z()});
    vecs.push_back('{wr(104, 9),            e(0, 1, 1, 104, 9, 0),   e(0, 0, 0, 0, 0, 1)});
    vecs.push_back('{wr(100, 25),           e(0, 1, 1, 104, 9, 0),   e(1, 0, 0, 0, 0, 2)});
    vecs.push_back('{clr(0),                z(), z()});
    vecs.push_back('{st(),                  z(), z()});
    vecs.push_back('{wr(200, 1),            e(0, 1, 1, 200, 1, 0),   e(0, 1, 1, 200, 1, 0)});
    vecs.push_back('{clr(0),                z(), z()});
    vecs.push_back('{st(),                  z(), z()});
    vecs.push_back('{cfg(0, 0, 300, 1),     z(), z()});
    vecs.push_back('{wr(100, 25),           e(0, 0, 0, 0, 0, 1),     e(0, 0, 0, 0, 0, 1)});
    vecs.push_back('{wr(104, 9),            e(1, 0, 0, 0, 0, 2),     e(1, 0, 0, 0, 0, 2)});
    vecs.push_back('{clr(0),                z(), z()});

    foreach (vecs[k]) begin
      apply(vecs[k].i);
      check_both($sformatf("vec%0d", k), vecs[k].a, vecs[k].b);
    end

    // Timeout lands exactly 16 cycles after RUN entry.
    apply(st());
    for (int i = 1; i <= 16; i++) begin
      apply(nop());
      if (i < 16) check_both($sformatf("tmo%0d", i), z(), z());
      else        check_both("tmo16", e(0, 1, 3, 0, 0, 0), e(0, 1, 3, 0, 0, 0));
    end
    apply(clr(0));

    // Final match in the timeout cycle must yield PASS.
    apply(st());
    for (int i = 1; i <= 16; i++) begin
      if (i == 1)       apply(wr(100, 25));
      else if (i == 16) apply(wr(104, 9));
      else              apply(nop());
      if (i < 16) check_both($sformatf("race%0d", i), e(0, 0, 0, 0, 0, 1), e(0, 0, 0, 0, 0, 1));
      else        check_both("race16", e(1, 0, 0, 0, 0, 2), e(1, 0, 0, 0, 0, 2));
    end
    apply(clr(0));

    // Reset mid-RUN wipes outputs and tables.
    apply(st());
    apply(wr(100, 25));
    check_both("mid.run", e(0, 0, 0, 0, 0, 1), e(0, 0, 0, 0, 0, 1));
    apply(rst_i());
    check_both("mid.rst", z(), z());
    apply(wr(104, 9));
    check_both("post.rst.idle", z(), z());
    apply(st());
    check_both("empty.start", e(1, 0, 0, 0, 0, 0), e(1, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
